// File: rtl/id_ex_stage_pkg.sv
// Shared datapath constants for the ID/EX slice plus the operand forward-select encoding.
package id_ex_stage_pkg;

  localparam int WORD_WIDTH  = 64;
  localparam logic [WORD_WIDTH-1:0] WORD_ZERO = '0;
  localparam int vADDR_WIDTH = 5;
  localparam logic [vADDR_WIDTH-1:0] vADDR_ZERO = '0;

  typedef enum logic [1:0] {
    FWD_RF  = 2'd0,
    FWD_EX  = 2'd1,
    FWD_MEM = 2'd2,
    FWD_WB  = 2'd3
  } fwdSel_e;

endpackage

// File: rtl/id_ex_stage_fwd_mux.sv
// Per-operand forwarding mux: picks the youngest producer of rs (EX > MEM > WB > RF)
// and flags a load-use hazard when the EX producer is a load still in flight.
module id_ex_stage_fwd_mux
  import id_ex_stage_pkg::*;
#(
  parameter int WORD_W  = WORD_WIDTH,
  parameter int RADDR_W = vADDR_WIDTH
) (
  input  logic [RADDR_W-1:0] rs,
  input  logic               used,
  input  logic               exVld,
  input  logic               exWe,
  input  logic               exIsLoad,
  input  logic [RADDR_W-1:0] exRd,
  input  logic [WORD_W-1:0]  exData,
  input  logic               memWe,
  input  logic [RADDR_W-1:0] memRd,
  input  logic [WORD_W-1:0]  memData,
  input  logic               wbWe,
  input  logic [RADDR_W-1:0] wbRd,
  input  logic [WORD_W-1:0]  wbData,
  input  logic [WORD_W-1:0]  rfData,
  output logic [WORD_W-1:0]  value,
  output logic               loadHazard
);

  logic    rsLive;
  logic    exHit;
  fwdSel_e sel;

  always_comb begin
    rsLive     = (rs != RADDR_W'(vADDR_ZERO));
    exHit      = rsLive & exVld & exWe & (exRd == rs);
    loadHazard = used & exHit & exIsLoad;

    sel = FWD_RF;
    if (exHit && !exIsLoad) begin
      sel = FWD_EX;
    end else if (rsLive && memWe && (memRd == rs)) begin
      sel = FWD_MEM;
    end else if (rsLive && wbWe && (wbRd == rs)) begin
      sel = FWD_WB;
    end

    // x0 is hard-wired: whatever the register file returns is ignored
    value = WORD_W'(WORD_ZERO);
    if (rsLive) begin
      case (sel)
        FWD_EX:  value = exData;
        FWD_MEM: value = memData;
        FWD_WB:  value = wbData;
        default: value = rfData;
      endcase
    end
  end

endmodule

// File: rtl/id_ex_stage.sv
// ID/EX pipeline register: resolves forwarded operands, inserts load-use bubbles,
// honours back-pressure and flush, and counts hazard bubbles.
module id_ex_stage
  import id_ex_stage_pkg::*;
#(
  parameter int WORD_W  = WORD_WIDTH,
  parameter int RADDR_W = vADDR_WIDTH,
  parameter int OP_W    = 6,
  parameter int CNT_W   = 32
) (
  input  logic               clk_i,
  input  logic               rst_ni,
  input  logic               id_valid_i,
  input  logic [RADDR_W-1:0] id_rs1_i,
  input  logic [RADDR_W-1:0] id_rs2_i,
  input  logic               id_rs1_used_i,
  input  logic               id_rs2_used_i,
  input  logic [RADDR_W-1:0] id_rd_i,
  input  logic               id_rd_we_i,
  input  logic               id_is_load_i,
  input  logic [WORD_W-1:0]  id_imm_i,
  input  logic [WORD_W-1:0]  id_pc_i,
  input  logic [OP_W-1:0]    id_op_i,
  input  logic [WORD_W-1:0]  rf_rs1_data_i,
  input  logic [WORD_W-1:0]  rf_rs2_data_i,
  input  logic [WORD_W-1:0]  ex_result_i,
  input  logic [RADDR_W-1:0] mem_rd_i,
  input  logic               mem_we_i,
  input  logic [WORD_W-1:0]  mem_data_i,
  input  logic [RADDR_W-1:0] wb_rd_i,
  input  logic               wb_we_i,
  input  logic [WORD_W-1:0]  wb_data_i,
  input  logic               ex_ready_i,
  input  logic               flush_i,
  output logic               stall_o,
  output logic               ex_valid_o,
  output logic [WORD_W-1:0]  ex_rs1_val_o,
  output logic [WORD_W-1:0]  ex_rs2_val_o,
  output logic [RADDR_W-1:0] ex_rd_o,
  output logic               ex_rd_we_o,
  output logic               ex_is_load_o,
  output logic [WORD_W-1:0]  ex_imm_o,
  output logic [WORD_W-1:0]  ex_pc_o,
  output logic [OP_W-1:0]    ex_op_o,
  output logic [CNT_W-1:0]   stall_cnt_o
);

  function automatic logic [CNT_W-1:0] satInc(input logic [CNT_W-1:0] cnt);
    return (&cnt) ? cnt : cnt + CNT_W'(1);
  endfunction

  logic [WORD_W-1:0]  rs1Val_p0, rs2Val_p0;
  logic               rs1Haz_p0, rs2Haz_p0;
  logic               hazard_p0;
  logic               takeLoad_p0, takeBubble_p0;

  logic               vld_p1;
  logic [WORD_W-1:0]  rs1Val_p1, rs2Val_p1;
  logic [RADDR_W-1:0] rd_p1;
  logic               rdWe_p1;
  logic               isLoad_p1;
  logic [WORD_W-1:0]  imm_p1, pc_p1;
  logic [OP_W-1:0]    op_p1;
  logic [CNT_W-1:0]   stallCnt_p1;

  // ---- stage p0: ID-side operand resolution and hazard detection ----
  id_ex_stage_fwd_mux #(.WORD_W(WORD_W), .RADDR_W(RADDR_W)) uFwdRs1 (
    .rs(id_rs1_i), .used(id_rs1_used_i),
    .exVld(vld_p1), .exWe(rdWe_p1), .exIsLoad(isLoad_p1), .exRd(rd_p1), .exData(ex_result_i),
    .memWe(mem_we_i), .memRd(mem_rd_i), .memData(mem_data_i),
    .wbWe(wb_we_i), .wbRd(wb_rd_i), .wbData(wb_data_i),
    .rfData(rf_rs1_data_i), .value(rs1Val_p0), .loadHazard(rs1Haz_p0)
  );

  id_ex_stage_fwd_mux #(.WORD_W(WORD_W), .RADDR_W(RADDR_W)) uFwdRs2 (
    .rs(id_rs2_i), .used(id_rs2_used_i),
    .exVld(vld_p1), .exWe(rdWe_p1), .exIsLoad(isLoad_p1), .exRd(rd_p1), .exData(ex_result_i),
    .memWe(mem_we_i), .memRd(mem_rd_i), .memData(mem_data_i),
    .wbWe(wb_we_i), .wbRd(wb_rd_i), .wbData(wb_data_i),
    .rfData(rf_rs2_data_i), .value(rs2Val_p0), .loadHazard(rs2Haz_p0)
  );

  assign hazard_p0     = id_valid_i & (rs1Haz_p0 | rs2Haz_p0);
  assign stall_o       = hazard_p0 | ~ex_ready_i;
  assign takeLoad_p0   = ~flush_i & ex_ready_i & ~hazard_p0;
  assign takeBubble_p0 = ~flush_i & ex_ready_i & hazard_p0;

  // ---- stage p1: EX-facing pipeline register ----
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      vld_p1      <= 1'b0;
      rdWe_p1     <= 1'b0;
      isLoad_p1   <= 1'b0;
      stallCnt_p1 <= '0;
    end else begin
      if (flush_i) begin
        vld_p1 <= 1'b0;
      end else if (takeBubble_p0) begin
        vld_p1      <= 1'b0;
        rdWe_p1     <= 1'b0;
        isLoad_p1   <= 1'b0;
        stallCnt_p1 <= satInc(stallCnt_p1);
      end else if (takeLoad_p0) begin
        vld_p1    <= id_valid_i;
        rdWe_p1   <= id_valid_i & id_rd_we_i;
        isLoad_p1 <= id_valid_i & id_is_load_i;
      end
    end
  end

  // Operands are captured only when the instruction actually advances into EX
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      rs1Val_p1 <= '0;
      rs2Val_p1 <= '0;
      rd_p1     <= '0;
      imm_p1    <= '0;
      pc_p1     <= '0;
      op_p1     <= '0;
    end else if (takeLoad_p0) begin
      rs1Val_p1 <= rs1Val_p0;
      rs2Val_p1 <= rs2Val_p0;
      rd_p1     <= id_rd_i;
      imm_p1    <= id_imm_i;
      pc_p1     <= id_pc_i;
      op_p1     <= id_op_i;
    end
  end

  assign ex_valid_o   = vld_p1;
  assign ex_rs1_val_o = rs1Val_p1;
  assign ex_rs2_val_o = rs2Val_p1;
  assign ex_rd_o      = rd_p1;
  assign ex_rd_we_o   = rdWe_p1;
  assign ex_is_load_o = isLoad_p1;
  assign ex_imm_o     = imm_p1;
  assign ex_pc_o      = pc_p1;
  assign ex_op_o      = op_p1;
  assign stall_cnt_o  = stallCnt_p1;

endmodule

// File: tb/tb_id_ex_stage.sv
// Bench for id_ex_stage: directed forwarding/hazard/stall/reset steps, then random traffic
// against a reference model; a narrow-counter instance exercises saturation.
module tb_id_ex_stage;

  localparam int WW = 64;
  localparam int RW = 5;
  localparam int OW = 6;
  localparam int CW = 32;
  localparam int SW = 4;

  logic          clk = 1'b0;
  logic          rst_n;
  logic          id_valid, id_rs1_used, id_rs2_used, id_rd_we, id_is_load;
  logic [RW-1:0] id_rs1, id_rs2, id_rd, mem_rd, wb_rd;
  logic [WW-1:0] id_imm, id_pc, rf_rs1, rf_rs2, ex_result, mem_data, wb_data;
  logic [OW-1:0] id_op;
  logic          mem_we, wb_we, ex_ready, flush;

  logic          stall, ex_valid, ex_rd_we, ex_is_load;
  logic [WW-1:0] ex_rs1_val, ex_rs2_val, ex_imm, ex_pc;
  logic [RW-1:0] ex_rd;
  logic [OW-1:0] ex_op;
  logic [CW-1:0] stall_cnt;

  logic          sStall, sValid, sRdWe, sIsLoad;
  logic [WW-1:0] sRs1, sRs2, sImm, sPc;
  logic [RW-1:0] sRd;
  logic [OW-1:0] sOp;
  logic [SW-1:0] sCnt;

  int checks = 0;
  int errors = 0;

  // reference model of the EX-facing state
  logic          mValid, mWe, mLoad;
  logic [RW-1:0] mRd;
  logic [WW-1:0] mRs1, mRs2, mImm, mPc;
  logic [OW-1:0] mOp;
  logic [CW-1:0] mCnt;
  logic [SW-1:0] mSat;

  always #5 clk = ~clk;

  id_ex_stage dut (
    .clk_i(clk), .rst_ni(rst_n), .id_valid_i(id_valid),
    .id_rs1_i(id_rs1), .id_rs2_i(id_rs2), .id_rs1_used_i(id_rs1_used), .id_rs2_used_i(id_rs2_used),
    .id_rd_i(id_rd), .id_rd_we_i(id_rd_we), .id_is_load_i(id_is_load),
    .id_imm_i(id_imm), .id_pc_i(id_pc), .id_op_i(id_op),
    .rf_rs1_data_i(rf_rs1), .rf_rs2_data_i(rf_rs2), .ex_result_i(ex_result),
    .mem_rd_i(mem_rd), .mem_we_i(mem_we), .mem_data_i(mem_data),
    .wb_rd_i(wb_rd), .wb_we_i(wb_we), .wb_data_i(wb_data),
    .ex_ready_i(ex_ready), .flush_i(flush), .stall_o(stall),
    .ex_valid_o(ex_valid), .ex_rs1_val_o(ex_rs1_val), .ex_rs2_val_o(ex_rs2_val),
    .ex_rd_o(ex_rd), .ex_rd_we_o(ex_rd_we), .ex_is_load_o(ex_is_load),
    .ex_imm_o(ex_imm), .ex_pc_o(ex_pc), .ex_op_o(ex_op), .stall_cnt_o(stall_cnt)
  );

  id_ex_stage #(.CNT_W(SW)) satDut (
    .clk_i(clk), .rst_ni(rst_n), .id_valid_i(id_valid),
    .id_rs1_i(id_rs1), .id_rs2_i(id_rs2), .id_rs1_used_i(id_rs1_used), .id_rs2_used_i(id_rs2_used),
    .id_rd_i(id_rd), .id_rd_we_i(id_rd_we), .id_is_load_i(id_is_load),
    .id_imm_i(id_imm), .id_pc_i(id_pc), .id_op_i(id_op),
    .rf_rs1_data_i(rf_rs1), .rf_rs2_data_i(rf_rs2), .ex_result_i(ex_result),
    .mem_rd_i(mem_rd), .mem_we_i(mem_we), .mem_data_i(mem_data),
    .wb_rd_i(wb_rd), .wb_we_i(wb_we), .wb_data_i(wb_data),
    .ex_ready_i(ex_ready), .flush_i(flush), .stall_o(sStall),
    .ex_valid_o(sValid), .ex_rs1_val_o(sRs1), .ex_rs2_val_o(sRs2),
    .ex_rd_o(sRd), .ex_rd_we_o(sRdWe), .ex_is_load_o(sIsLoad),
    .ex_imm_o(sImm), .ex_pc_o(sPc), .ex_op_o(sOp), .stall_cnt_o(sCnt)
  );

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic idle();
    id_valid = 0; id_rs1 = 0; id_rs2 = 0; id_rs1_used = 0; id_rs2_used = 0;
    id_rd = 0; id_rd_we = 0; id_is_load = 0; id_imm = 0; id_pc = 0; id_op = 0;
    rf_rs1 = 0; rf_rs2 = 0; ex_result = 0;
    mem_rd = 0; mem_we = 0; mem_data = 0; wb_rd = 0; wb_we = 0; wb_data = 0;
    ex_ready = 1; flush = 0;
  endtask

  task automatic setId(input logic v, input logic [RW-1:0] r1, input logic u1,
                       input logic [RW-1:0] r2, input logic u2,
                       input logic [RW-1:0] rd, input logic we, input logic ld);
    id_valid = v; id_rs1 = r1; id_rs1_used = u1; id_rs2 = r2; id_rs2_used = u2;
    id_rd = rd; id_rd_we = we; id_is_load = ld;
  endtask

  // Architectural value of rs as seen by the instruction in ID
  function automatic logic [WW-1:0] resolve(input logic [RW-1:0] rs, input logic [WW-1:0] rf);
    if (rs == 0) return '0;
    if (mValid && mWe && !mLoad && mRd == rs) return ex_result;
    if (mem_we && mem_rd == rs) return mem_data;
    if (wb_we && wb_rd == rs) return wb_data;
    return rf;
  endfunction

  task automatic checkAll();
    chk("valid", ex_valid, mValid);   chk("s_valid", sValid, mValid);
    chk("rd_we", ex_rd_we, mWe);      chk("s_rd_we", sRdWe, mWe);
    chk("is_load", ex_is_load, mLoad); chk("s_is_load", sIsLoad, mLoad);
    chk("rd", ex_rd, mRd);            chk("s_rd", sRd, mRd);
    chk("rs1_val", ex_rs1_val, mRs1); chk("s_rs1_val", sRs1, mRs1);
    chk("rs2_val", ex_rs2_val, mRs2); chk("s_rs2_val", sRs2, mRs2);
    chk("imm", ex_imm, mImm);         chk("s_imm", sImm, mImm);
    chk("pc", ex_pc, mPc);            chk("s_pc", sPc, mPc);
    chk("op", ex_op, mOp);            chk("s_op", sOp, mOp);
    chk("cnt", stall_cnt, mCnt);      chk("s_cnt", sCnt, mSat);
  endtask

  initial begin
    logic          hz;
    logic [WW-1:0] e1, e2;

    idle();
    rst_n = 0;
    tick();
    chk("rst_valid", ex_valid, 0);
    chk("rst_cnt", stall_cnt, 0);
    chk("rst_rs1", ex_rs1_val, 0);
    chk("rst_pc", ex_pc, 0);
    chk("rst_stall", stall, 0);
    rst_n = 1;

    // back-to-back dependency through EX
    setId(1, 0, 0, 0, 0, 5, 1, 0);
    tick();
    chk("b2b_a_valid", ex_valid, 1);
    chk("b2b_a_rd", ex_rd, 5);
    setId(1, 5, 1, 0, 0, 6, 1, 0);
    ex_result = 64'h11; rf_rs1 = 64'hDEAD;
    #1 chk("b2b_stall", stall, 0);
    tick();
    chk("b2b_rs1", ex_rs1_val, 64'h11);
    chk("b2b_valid", ex_valid, 1);

    // forwarding priority EX > MEM > WB > RF
    idle();
    setId(1, 0, 0, 0, 0, 7, 1, 0);
    tick();
    setId(1, 7, 1, 7, 1, 8, 1, 0);
    ex_result = 64'hAA; mem_we = 1; mem_rd = 7; mem_data = 64'hBB;
    wb_we = 1; wb_rd = 7; wb_data = 64'hCC; rf_rs2 = 64'h1234;
    tick();
    chk("prio_ex", ex_rs2_val, 64'hAA);
    tick();
    chk("prio_mem", ex_rs2_val, 64'hBB);
    mem_we = 0;
    tick();
    chk("prio_wb", ex_rs2_val, 64'hCC);
    wb_we = 0;
    tick();
    chk("prio_rf", ex_rs2_val, 64'h1234);

    // load-use: one bubble, then load data from MEM
    idle();
    setId(1, 0, 0, 0, 0, 3, 1, 1);
    tick();
    setId(1, 0, 0, 3, 1, 9, 1, 0);
    rf_rs2 = 64'h99;
    #1 chk("lu_stall", stall, 1);
    tick();
    chk("lu_bubble", ex_valid, 0);
    chk("lu_cnt", stall_cnt, 1);
    mem_we = 1; mem_rd = 3; mem_data = 64'h55;
    #1 chk("lu_stall_clear", stall, 0);
    tick();
    chk("lu_rs2", ex_rs2_val, 64'h55);
    chk("lu_valid", ex_valid, 1);
    chk("lu_cnt_hold", stall_cnt, 1);

    // x0 is never forwarded or hazarded
    idle();
    setId(1, 0, 0, 0, 0, 0, 1, 1);
    tick();
    chk("x0_ex_load", ex_is_load, 1);
    setId(1, 0, 1, 0, 1, 2, 1, 0);
    rf_rs1 = 64'h77; rf_rs2 = 64'h77; ex_result = 1;
    mem_we = 1; mem_rd = 0; mem_data = 64'h88; wb_we = 1; wb_rd = 0; wb_data = 64'h99;
    #1 chk("x0_stall", stall, 0);
    tick();
    chk("x0_rs1", ex_rs1_val, 0);
    chk("x0_rs2", ex_rs2_val, 0);
    chk("x0_valid", ex_valid, 1);

    // back-pressure holds everything, then flush under back-pressure
    idle();
    setId(1, 0, 0, 0, 0, 10, 1, 0);
    id_pc = 64'h1000; id_imm = 64'h42;
    tick();
    chk("bp_pc0", ex_pc, 64'h1000);
    setId(1, 0, 0, 0, 0, 11, 1, 0);
    id_pc = 64'h2000; ex_ready = 0;
    for (int i = 0; i < 3; i++) begin
      #1 chk("bp_stall", stall, 1);
      tick();
      chk("bp_pc", ex_pc, 64'h1000);
      chk("bp_rd", ex_rd, 10);
      chk("bp_valid", ex_valid, 1);
      chk("bp_cnt", stall_cnt, 1);
    end
    flush = 1;
    tick();
    chk("flush_valid", ex_valid, 0);
    chk("flush_cnt", stall_cnt, 1);

    // repeated load-use pairs drive the narrow counter into saturation
    for (int k = 1; k <= 16; k++) begin
      idle();
      setId(1, 0, 0, 0, 0, 3, 1, 1);
      tick();
      setId(1, 3, 1, 0, 0, 4, 1, 0);
      tick();
      chk("sat_cnt_wide", stall_cnt, 1 + k);
      chk("sat_cnt_narrow", sCnt, (1 + k > 15) ? 15 : 1 + k);
    end

    // asynchronous reset mid-cycle with a valid instruction held and a saturated counter
    idle();
    setId(1, 0, 0, 0, 0, 12, 1, 0);
    id_pc = 64'h3000;
    tick();
    chk("ar_pre_valid", ex_valid, 1);
    #3 rst_n = 0;
    #1;
    chk("ar_valid", ex_valid, 0);
    chk("ar_pc", ex_pc, 0);
    chk("ar_rd", ex_rd, 0);
    chk("ar_rd_we", ex_rd_we, 0);
    chk("ar_cnt", stall_cnt, 0);
    chk("ar_sat_cnt", sCnt, 0);
    chk("ar_stall", stall, 0);
    ex_ready = 0;
    #1 chk("ar_stall_bp", stall, 1);
    ex_ready = 1;
    tick();
    chk("ar_hold_valid", ex_valid, 0);
    rst_n = 1;

    // random traffic against the reference model
    mValid = 0; mWe = 0; mLoad = 0; mRd = 0; mRs1 = 0; mRs2 = 0;
    mImm = 0; mPc = 0; mOp = 0; mCnt = 0; mSat = 0;
    for (int n = 0; n < 400; n++) begin
      id_valid = ($urandom_range(0, 3) != 0);
      id_rs1 = RW'($urandom_range(0, 7)); id_rs2 = RW'($urandom_range(0, 7));
      id_rs1_used = $urandom_range(0, 1) == 1; id_rs2_used = $urandom_range(0, 1) == 1;
      id_rd = RW'($urandom_range(0, 7)); id_rd_we = $urandom_range(0, 3) != 0;
      id_is_load = $urandom_range(0, 2) == 0;
      id_imm = {$urandom, $urandom}; id_pc = {$urandom, $urandom}; id_op = OW'($urandom);
      rf_rs1 = {$urandom, $urandom}; rf_rs2 = {$urandom, $urandom};
      ex_result = {$urandom, $urandom};
      mem_we = $urandom_range(0, 1) == 1; mem_rd = RW'($urandom_range(0, 7));
      mem_data = {$urandom, $urandom};
      wb_we = $urandom_range(0, 1) == 1; wb_rd = RW'($urandom_range(0, 7));
      wb_data = {$urandom, $urandom};
      ex_ready = ($urandom_range(0, 7) != 0);
      flush = ($urandom_range(0, 15) == 0);

      hz = id_valid && mValid && mLoad && mWe && (mRd != 0) &&
           ((id_rs1_used && id_rs1 == mRd) || (id_rs2_used && id_rs2 == mRd));
      e1 = resolve(id_rs1, rf_rs1);
      e2 = resolve(id_rs2, rf_rs2);
      #1 chk("rnd_stall", stall, hz || !ex_ready);
      tick();

      if (flush) begin
        mValid = 0;
      end else if (!ex_ready) begin
        mValid = mValid;
      end else if (hz) begin
        mValid = 0; mWe = 0; mLoad = 0;
        if (mCnt != '1) mCnt = mCnt + 1;
        if (mSat != '1) mSat = mSat + 1;
      end else begin
        mValid = id_valid; mWe = id_valid && id_rd_we; mLoad = id_valid && id_is_load;
        mRd = id_rd; mRs1 = e1; mRs2 = e2; mImm = id_imm; mPc = id_pc; mOp = id_op;
      end
      checkAll();
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
